// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the memory stage: opcode ranges, access
// sizes, byte-enable bases, FSM states and the held-instruction record.
package pipe_pkg;

  localparam logic [4:0] OP_WORD_LO = 5'd3;
  localparam logic [4:0] OP_WORD_HI = 5'd5;
  localparam logic [4:0] OP_HALF_LO = 5'd6;
  localparam logic [4:0] OP_HALF_HI = 5'd8;
  localparam logic [4:0] OP_BYTE_LO = 5'd9;
  localparam logic [4:0] OP_BYTE_HI = 5'd11;
  localparam logic [4:0] OP_BRI     = 5'd12;

  localparam logic [3:0] BE_BASE_WORD = 4'b1111;
  localparam logic [3:0] BE_BASE_HALF = 4'b0011;
  localparam logic [3:0] BE_BASE_BYTE = 4'b0001;

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  tgt_1;
    logic [4:0]  tgt_2;
    logic [31:0] alu_1;
    logic [31:0] alu_2;
    logic [31:0] sdata;
    logic        is_load;
    logic        is_store;
  } mem_op_t;

  function automatic size_t size_of(input logic [4:0] op);
    if (op >= OP_WORD_LO && op <= OP_WORD_HI) return SZ_WORD;
    if (op >= OP_HALF_LO && op <= OP_HALF_HI) return SZ_HALF;
    if (op >= OP_BYTE_LO && op <= OP_BYTE_HI) return SZ_BYTE;
    return SZ_NONE;
  endfunction

  // An access is misaligned when it does not fit inside one RAM word.
  function automatic logic misaligned(input size_t sz, input logic [1:0] o);
    case (sz)
      SZ_WORD: return o != 2'd0;
      SZ_HALF: return o == 2'd3;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane steering: byte enables and shifted write data for beat A (the
// addressed word) or beat B (the bytes that spill into the following word).
module store_align
  import pipe_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        beat_b,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic [3:0]  base;
  logic [7:0]  be_ext;
  logic [63:0] wd_ext;

  // Shift into a double-width window: low half is beat A, high half is beat B
  always_comb begin
    case (size)
      SZ_WORD: base = BE_BASE_WORD;
      SZ_HALF: base = BE_BASE_HALF;
      SZ_BYTE: base = BE_BASE_BYTE;
      default: base = 4'b0000;
    endcase
    be_ext = {4'b0000, base} << offset;
    wd_ext = {32'd0, data} << {offset, 3'b000};
    be     = beat_b ? be_ext[7:4] : be_ext[3:0];
    wdata  = beat_b ? wd_ext[63:32] : wd_ext[31:0];
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives the synchronous data RAM from the execute result and
// registers pipeline info for writeback. Misaligned word/halfword accesses are
// split into two RAM beats with a one-cycle upstream stall. Defining
// MEM_ALIGN_TRAP_EN replaces splitting with a registered misalign_trap pulse.
module mem_access
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              bubble_in,
  input  logic [4:0]        opcode_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [4:0]        tgt_in_1,
  input  logic [4:0]        tgt_in_2,
  input  logic [31:0]       alu_result_1_in,
  input  logic [31:0]       alu_result_2_in,
  input  logic [31:0]       store_data,
  output logic              stall_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic              bubble_out,
  output logic [4:0]        opcode,
  output logic [4:0]        tgt_out_1,
  output logic [4:0]        tgt_out_2,
  output logic [31:0]       alu_result_1,
  output logic [31:0]       alu_result_2,
  output logic [ADDR_W-1:0] addr,
  output logic              is_load,
  output logic              is_store,
  output logic              is_misaligned
`ifdef MEM_ALIGN_TRAP_EN
  ,
  output logic              misalign_trap
`endif
);

  mem_op_t           in_op;
  mem_op_t           cur;
  size_t             in_sz;
  size_t             cur_sz;
  logic              in_split;
  logic              in_acc;
  logic              in_mis;
  logic              fire;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [ADDR_W-1:0] base_addr;

  assign in_op = '{opcode: opcode_in, tgt_1: tgt_in_1, tgt_2: tgt_in_2,
                   alu_1: alu_result_1_in, alu_2: alu_result_2_in,
                   sdata: store_data, is_load: is_load_in, is_store: is_store_in};

  assign in_sz  = size_of(opcode_in);
  assign in_acc = !bubble_in && (is_load_in || is_store_in) && (in_sz != SZ_NONE);
  assign in_mis = in_acc && misaligned(in_sz, alu_result_1_in[1:0]);

`ifdef MEM_ALIGN_TRAP_EN
  assign in_split = 1'b0;
  assign cur      = in_op;
`else
  state_t  state;
  state_t  state_n;
  mem_op_t hold;

  assign in_split = (state == SPLIT);
  // Beat B replays the held instruction; execute inputs are ignored then.
  assign cur      = in_split ? hold : in_op;

  // FSM state register; halt freezes it, reset aborts a pending split
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (!halt) begin
      state <= state_n;
    end
  end

  // Capture the instruction on beat A so beat B can be issued from it
  always_ff @(posedge clk) begin
    if (!halt && !in_split && in_mis) begin
      hold <= in_op;
    end
  end
`endif

  assign cur_sz    = size_of(cur.opcode);
  assign base_addr = {cur.alu_1[ADDR_W-1:2], 2'b00};

  store_align u_store_align (
    .size   (cur_sz),
    .offset (cur.alu_1[1:0]),
    .beat_b (in_split),
    .data   (cur.sdata),
    .be     (al_be),
    .wdata  (al_wdata)
  );

  // Next state, stall and RAM port drive for the current beat
  always_comb begin
    fire      = 1'b0;
    stall_out = 1'b0;
    mem_re    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = in_split ? base_addr + ADDR_W'(4) : base_addr;
    mem_wdata = al_wdata;
`ifdef MEM_ALIGN_TRAP_EN
    fire = in_acc && !in_mis;
`else
    state_n = state;
    if (in_split) begin
      fire    = 1'b1;
      state_n = IDLE;
    end else if (in_acc) begin
      fire = 1'b1;
      if (in_mis) begin
        stall_out = 1'b1;
        state_n   = SPLIT;
      end
    end
`endif
    if (rst) begin
      stall_out = 1'b0;
    end
    if (fire && !halt && !rst) begin
      mem_re = cur.is_load;
      mem_be = cur.is_store ? al_be : 4'b0000;
    end
  end

  // Writeback pipeline register; beat A goes out as a bubble flagged misaligned
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_out    <= 1'b1;
      opcode        <= '0;
      tgt_out_1     <= '0;
      tgt_out_2     <= '0;
      alu_result_1  <= '0;
      alu_result_2  <= '0;
      addr          <= '0;
      is_load       <= 1'b0;
      is_store      <= 1'b0;
      is_misaligned <= 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else if (!halt) begin
      bubble_out    <= in_split ? 1'b0 : (bubble_in | in_mis);
      opcode        <= cur.opcode;
      tgt_out_1     <= cur.tgt_1;
      tgt_out_2     <= cur.tgt_2;
      alu_result_1  <= cur.alu_1;
      alu_result_2  <= cur.alu_2;
      addr          <= cur.alu_1[ADDR_W-1:0];
      is_load       <= cur.is_load;
      is_store      <= cur.is_store;
      is_misaligned <= !in_split && in_mis;
`ifdef MEM_ALIGN_TRAP_EN
      misalign_trap <= in_mis;
`endif
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage; sits directly upstream of writeback.
- Takes the registered execute-stage result and drives the synchronous data RAM port (1-cycle read latency).
- Generates word-aligned addresses, byte enables and shifted store data.
- Splits misaligned word and halfword accesses into two RAM beats and stalls upstream for one cycle.
- Registers pipeline info for writeback. Writeback receives `mem_rdata` directly as its memory result.

Parameters:
- ADDR_W, 32, byte-address width; `mem_addr` is always word-aligned, with bits [1:0] = 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- halt  in  1  freeze all state; no RAM enables asserted
- bubble_in  in  1  execute slot is invalid
- opcode_in  in  5  3-5 word, 6-8 half, 9-11 byte, 12 immediate branch
- is_load_in  in  1  load
- is_store_in  in  1  store
- tgt_in_1  in  5  dest reg 1
- tgt_in_2  in  5  dest reg 2
- alu_result_1_in  in  32  ALU result 1; also used as the byte address for loads and stores
- alu_result_2_in  in  32  ALU result 2
- store_data  in  32  store value, right-justified
- stall_out  out  1  upstream must hold its registers this cycle
- mem_addr  out  ADDR_W  word address to RAM
- mem_re  out  1  read enable
- mem_be  out  4  byte write enables; bit i = byte i, little-endian
- mem_wdata  out  32  write data
- bubble_out, opcode, tgt_out_1, tgt_out_2, alu_result_1, alu_result_2, addr, is_load, is_store, is_misaligned  out  as in  registered to writeback

Behaviour:
- Reset:
  - state = IDLE.
  - `bubble_out` = 1; all other registered outputs = 0.
  - `stall_out`, `mem_re` and `mem_be` = 0.
- Misalignment rule, with `o = alu_result_1_in[1:0]`:
  - word: misaligned if `o != 0`;
  - halfword: misaligned if `o == 3`;
  - byte: never misaligned.
- IDLE, valid, aligned access:
  - `mem_addr = {addr[ADDR_W-1:2], 2'b00}`.
  - `mem_re = is_load_in`.
  - Stores: `mem_be = base << o`, where base = 1111 (word), 0011 (half) or 0001 (byte); `mem_wdata = store_data << 8*o`.
  - Next edge registers outputs with `is_misaligned = 0`.
- IDLE, valid, misaligned access (beat A):
  - Access word W at the aligned address.
  - Assert `stall_out = 1` combinationally.
  - Latch the instruction into a hold register.
  - Go to SPLIT.
  - Registered output: `bubble_out = 1`, `is_misaligned = 1`, `is_load`/`is_store` and `addr` valid.
- SPLIT (beat B):
  - Access W+4 from the held instruction; `stall_out = 0`. Execute inputs are ignored this cycle because upstream holds them.
  - Registered output: `bubble_out = 0`, `is_misaligned = 0`, full held info.
  - Return to IDLE.
  - Writeback therefore sees beat A data one cycle, then beat B data the next.
- Store split values:
  - word at offset o: beat A `be = 1111 << o`, `wdata = d << 8o`; beat B `be = 1111 >> (4-o)`, `wdata = d >> 8(4-o)`.
  - halfword at o = 3: beat A `be = 1000`, `wdata = d << 24`; beat B `be = 0001`, `wdata = d >> 8`.
- Bubble, or opcode that is neither load nor store: no RAM enables; fields are passed through.
- `halt = 1`:
  - No state, hold-register or output changes.
  - `mem_re` and `mem_be` forced to 0.
  - `stall_out` holds its value.
  - On de-halt, the pending beat is reissued.
- Address wrap: W+4 wraps modulo 2^ADDR_W.
- `rst` during SPLIT: the split is aborted, beat B is never issued, and state returns to IDLE. `rst` has priority over `halt`.

Optional Feature:
- Macro: MEM_ALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are not split; no `stall_out` and no RAM enables.
  - Adds output `misalign_trap` (1 bit), registered and pulsed for one cycle with `bubble_out = 1`.
  - SPLIT state is removed.
- Undefined: the splitting behaviour above; the port is absent.

Decomposition:
- Shared package `pipe_pkg`:
  - opcode range constants (OP_WORD_LO/HI = 3/5, OP_HALF = 6/8, OP_BYTE = 9/11, OP_BRI = 12);
  - state enum {IDLE, SPLIT};
  - byte-enable base constants.
- One sub-module, `store_align`: combinational function of (size, o, beat, data) returning (be, wdata).

Test Plan:
- Aligned word store, addr 0x100, data 0xDEADBEEF -> `mem_addr` 0x100, be 1111, wdata 0xDEADBEEF, no stall.
- Byte store, addr 0x103, data 0x5A -> be 1000, wdata 0x5A000000.
- Word load at addr 0x201 -> cycle 1: addr 0x200, re, stall 1, next `is_misaligned` 1 with bubble. Cycle 2: addr 0x204, re, no stall, next bubble 0.
- Halfword store at 0x7, data 0xABCD -> beat A addr 0x4, be 1000, wdata 0xCD000000; beat B addr 0x8, be 0001, wdata 0x000000AB.
- `rst` asserted in SPLIT -> next cycle IDLE, no beat B, `bubble_out` 1, `stall_out` 0. `halt` during SPLIT -> outputs frozen, beat B issued after release.
- MEM_ALIGN_TRAP_EN: word load at 0x2 -> `misalign_trap` 1 for one cycle, no re/be, no stall.
